// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and fetch FSM state encoding.
// The TRAP state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package riscv_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] PC_INC           = 32'h4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM state type and its encodings
    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_RUN   = 2'd0;
    localparam fetch_state_t ST_DRAIN = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam fetch_state_t ST_TRAP  = 2'd2;
`endif

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding {instruction, pc} pairs for decode.
// Push while full is accepted only together with a pop; flush empties it.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers and occupancy; flush overrides push and pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents need no reset because count gates visibility
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: issues sequential instruction-memory requests, tags in-order
// responses with their pc and queues them for decode. Redirects flush the
// queue and discard responses to requests already in flight (DRAIN).
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned redirect enters a sticky
// TRAP state and raises misalign_trap; without it the target low bits are cleared.
//
// Handshakes: a transfer happens in a cycle where valid && ready are both high;
// a raised valid keeps its payload stable until it is taken (or a redirect
// replaces it). The memory response channel has no ready: it is always taken.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [31:0]       inst_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic              misalign_trap,
`endif
    output fetch_state_t      dbg_state_o
);
    localparam int           CW       = $clog2(QDEPTH + 1);
    localparam int           CW1      = CW + 1;
    localparam logic [CW:0]  QDEPTH_W = CW1'(QDEPTH);

    fetch_state_t        state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [31:0]         resp_pc_q, resp_pc_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;

    logic                req_fire, resp_fire, redirect_act;
    logic [31:0]         redirect_tgt;
    logic [CW:0]         occupancy;
    logic                q_push, q_pop, q_flush, q_full, q_empty;
    logic [CW-1:0]       q_count;
    logic [2*INST_W-1:0] q_rdata;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic redirect_bad;
    assign redirect_act  = redirect_valid && (state_q != ST_TRAP);
    assign redirect_bad  = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt  = redirect_pc;
    assign misalign_trap = trap_q;
`else
    assign redirect_act  = redirect_valid;
    assign redirect_tgt  = redirect_pc & ~32'h3;
`endif

    // Queued plus in-flight never exceeds QDEPTH, so every response has a slot
    assign occupancy      = {1'b0, q_count} + {1'b0, inflight_q};
    assign imem_req_valid = !rst && (state_q == ST_RUN) && (occupancy < QDEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored
    assign resp_fire      = imem_resp_valid && (inflight_q != '0);
    assign inflight_d     = inflight_q + CW'(req_fire) - CW'(resp_fire);

    assign inst_valid  = !q_empty;
    assign inst_data   = q_empty ? '0 : q_rdata[2*INST_W-1:INST_W];
    assign inst_pc     = q_empty ? '0 : q_rdata[31:0];
    // A redirect flushes the queue, so it wins over a same-cycle pop
    assign q_pop       = inst_valid && inst_ready && !redirect_act;
    assign dbg_state_o = state_q;

    // Next-state logic: redirects, response tagging, stale-response draining
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        q_push     = 1'b0;
        q_flush    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d     = trap_q;
`endif
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end
        if (redirect_act) begin
            // Everything still in flight (incl. a request taken this cycle,
            // minus a response arriving this cycle) is now stale.
            q_flush    = 1'b1;
            drop_cnt_d = inflight_d;
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            state_d    = (inflight_d != '0) ? ST_DRAIN : ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_bad) begin
                state_d = ST_TRAP;
                trap_d  = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (resp_fire && (!q_full || q_pop)) begin
                        q_push    = 1'b1;
                        resp_pc_d = resp_pc_q + PC_INC;
                    end
                end
                ST_DRAIN: begin
                    if (resp_fire && (drop_cnt_q != '0)) begin
                        drop_cnt_d = drop_cnt_q - CW'(1);
                        if (drop_cnt_q == CW'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    // TRAP: responses only retire the in-flight count
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q     <= trap_d;
`endif
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     (2 * INST_W)
    ) u_queue (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (q_flush),
        .push_i  (q_push),
        .wdata_i ({imem_resp_data, resp_pc_q}),
        .pop_i   (q_pop),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch with an in-order
// memory model of configurable latency and a pc-stream scoreboard.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  fetch_state_t dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_trap   (misalign_trap),
`endif
    .dbg_state_o     (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          last_due = -1;
  int          outstanding = 0;
  int          req_fires = 0;
  int          n_deliv = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_pc_q[$];
  logic [31:0] req_addr_log[$];
  bit          idle_next = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_log(input string name, input logic [31:0] q[$], input int idx,
                           input logic [31:0] exp);
    if (q.size() > idx) begin
      check(name, q[idx], exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d entries, expected %h at index %0d", name, q.size(), exp, idx);
    end
  endtask

  // Observe one cycle's transfers at the falling edge and update the model
  task automatic observe();
    bit redir;
    redir = redirect_valid;
    if (idle_next) check("inst_valid_after_redirect", inst_valid, 1'b0);
    if (prev_stall) begin
      check("req_hold_valid", imem_req_valid, 1'b1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      int due;
      outstanding++;
      req_fires++;
      req_addr_log.push_back(imem_req_addr);
      check("outstanding_le_qdepth", outstanding <= QDEPTH, 1'b1);
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(due);
    end
    if (imem_resp_valid) outstanding--;
    if (inst_valid && inst_ready && !redir) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("inst_pc", inst_pc, e);
      check("inst_data", inst_data, mem_word(e));
      exp_q.push_back(e + 32'h4);
      got_pc_q.push_back(inst_pc);
      n_deliv++;
    end
    if (redir) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_q.push_back(redirect_pc);
`else
      exp_q.push_back(redirect_pc & ~32'h3);
`endif
    end
    idle_next  = redir;
    prev_stall = imem_req_valid && !imem_req_ready && !redir;
    prev_addr  = imem_req_addr;
  endtask

  // Memory model: in-order responses, one per cycle, when due
  task automatic drive_mem();
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  task automatic step_pre();
    @(negedge clk);
  endtask

  task automatic step_post();
    observe();
    @(posedge clk);
    cyc++;
    #1;
    drive_mem();
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_req_ready  = 1'b1;
    inst_ready      = 1'b1;
    pend_addr.delete();
    pend_due.delete();
    last_due    = -1;
    outstanding = 0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    idle_next  = 1'b0;
    prev_stall = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_state_run", dbg_state, ST_RUN);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misalign_trap", misalign_trap, 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        inst_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        inst_valid;
    logic [31:0] inst_pc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Reset release, memory latency 1, decode always ready
    vecs[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    vecs[4] = '{1'b1, 1'b1, 32'hC, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8};

    #3;
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 6; i++) begin
      inst_ready = vecs[i].inst_ready;
      step_pre();
      check("vec_req_valid", imem_req_valid, vecs[i].req_valid);
      if (vecs[i].req_valid) check("vec_req_addr", imem_req_addr, vecs[i].req_addr);
      check("vec_inst_valid", inst_valid, vecs[i].inst_valid);
      if (vecs[i].inst_valid) check("vec_inst_pc", inst_pc, vecs[i].inst_pc);
      step_post();
    end

    // Decode stalled for 10 cycles: queue fills, then drains in order
    do_reset();
    mem_lat = 1;
    inst_ready = 1'b0;
    req_fires = 0;
    repeat (10) step();
    check("stall_req_count", req_fires, QDEPTH);
    check("stall_head_valid", inst_valid, 1'b1);
    check("stall_head_pc", inst_pc, 32'h0);
    got_pc_q.delete();
    inst_ready = 1'b1;
    repeat (10) step();
    check_log("stall_resume_pc0", got_pc_q, 0, 32'h0);
    check_log("stall_resume_pc1", got_pc_q, 1, 32'h4);
    check_log("stall_resume_pc2", got_pc_q, 2, 32'h8);

    // Redirect with two responses in flight
    do_reset();
    mem_lat = 3;
    repeat (2) step();
    got_pc_q.delete();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    step_pre();
    check("drain_state", dbg_state, ST_DRAIN);
    step_post();
    repeat (14) step();
    check_log("redir_first_pc", got_pc_q, 0, 32'h100);
    check_log("redir_second_pc", got_pc_q, 1, 32'h104);

    // Redirect coinciding with a response and a request acceptance
    do_reset();
    mem_lat = 1;
    step();
    got_pc_q.delete();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step_pre();
    check("coincide_req_fire", imem_req_valid && imem_req_ready, 1'b1);
    check("coincide_resp", imem_resp_valid, 1'b1);
    step_post();
    redirect_valid = 1'b0;
    repeat (12) step();
    check_log("coincide_first_pc", got_pc_q, 0, 32'h200);
    check_log("coincide_second_pc", got_pc_q, 1, 32'h204);

    // Address wrap at the top of the address space
    do_reset();
    mem_lat = 1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    req_addr_log.delete();
    got_pc_q.delete();
    repeat (10) step();
    check_log("wrap_req0", req_addr_log, 0, 32'hFFFF_FFFC);
    check_log("wrap_req1", req_addr_log, 1, 32'h0);
    check_log("wrap_pc1", got_pc_q, 1, 32'h0);

    // Misaligned redirect
    do_reset();
    mem_lat = 1;
    repeat (3) step();
    got_pc_q.delete();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      step_pre();
      check("trap_flag", misalign_trap, 1'b1);
      check("trap_req_idle", imem_req_valid, 1'b0);
      check("trap_inst_idle", inst_valid, 1'b0);
      step_post();
    end
`else
    repeat (12) step();
    check_log("misalign_masked_pc", got_pc_q, 0, 32'h100);
`endif

    // Randomized traffic with one mid-run reset
    do_reset();
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      if (i == 1500) do_reset();
      if (i % 200 == 0) mem_lat = $urandom_range(1, 4);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      r = $urandom();
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_pc = {r[31:2], 2'b00};
`else
      redirect_pc = r;
`endif
      step();
    end
    check("random_progress", n_deliv > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
